cla_pipe_addsub: RTL and testbench

Parametrised, pipelined signed adder/subtractor built from GROUP_W-bit carry-lookahead groups. It is the successor to the fixed 8-bit combinational CLA: width, group size and pipeline depth are generic, and it adds add/sub mode, carry-in and a valid/ready handshake. The result is sign-extended to WIDTH+1 bits, so it never overflows. It sits between operand-producing datapath stages and the downstream consumer.

---
 rtl/cla_pkg.sv | 19 +
 rtl/cla_group.sv | 49 ++++
 rtl/cla_pipe_addsub.sv | 165 ++++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared types and sizing helpers for the pipelined CLA adder/subtractor.
package cla_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Number of lookahead groups across a w-bit slice.
  function automatic int NGROUPS(input int w, input int g);
    return w / g;
  endfunction

  // Bits handled by each pipeline stage.
  function automatic int SLICE_W(input int w, input int s);
    return w / s;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP_W-bit carry-lookahead group: full lookahead on the internal
// carries, plus group propagate/generate for the next lookahead level.
module cla_group #(
  parameter int GROUP_W = 4
) (
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] s,
  output logic               p,
  output logic               g,
  output logic               cout
);

  logic [GROUP_W-1:0] pi, gi;
  logic [GROUP_W:0]   c;
  logic               pp, gacc;

  assign pi = a ^ b;
  assign gi = a & b;

  // Each carry is a flat sum of products of bit P/G and cin (no ripple);
  // the last pass also yields the group P and G.
  always_comb begin
    c    = '0;
    p    = 1'b0;
    g    = 1'b0;
    pp   = 1'b1;
    gacc = 1'b0;
    c[0] = cin;
    for (int i = 1; i <= GROUP_W; i++) begin
      pp   = 1'b1;
      gacc = 1'b0;
      for (int j = i - 1; j >= 0; j--) begin
        gacc = gacc | (pp & gi[j]);
        pp   = pp & pi[j];
      end
      c[i] = gacc | (pp & cin);
      if (i == GROUP_W) begin
        p = pp;
        g = gacc;
      end
    end
  end

  assign s    = pi ^ c[GROUP_W-1:0];
  assign cout = c[GROUP_W];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined signed add/sub. Each stage resolves one WIDTH/STAGES slice with
// lookahead groups and hands its carry, the partial sum and the untouched
// operand bits to the next stage. The result is one bit wider than the
// operands, so it never overflows.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int GROUP_W = 4,
  parameter int STAGES  = 2,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  op_e              in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [TAG_W-1:0] out_tag
);

  // WIDTH must be a multiple of GROUP_W*STAGES.
  localparam int SW = SLICE_W(WIDTH, STAGES);
  localparam int NG = NGROUPS(SW, GROUP_W);

  logic              en;
  logic [STAGES-1:0] vld_pipe;
  logic [WIDTH-1:0]  b_x;
  logic              c0;

  // The whole pipe moves in lockstep; it freezes only when the output slot
  // is occupied and not being taken, so nothing is lost or duplicated.
  assign out_valid = vld_pipe[STAGES-1];
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;

  // Subtraction is A + ~B + ~cin.
  assign b_x = (in_op == OP_SUB) ? ~in_b : in_b;
  assign c0  = (in_op == OP_SUB) ? ~in_cin : in_cin;

  // Valid shift register; stage 0 loads the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (en) begin
      vld_pipe[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : stg
    localparam int LO   = s * SW;
    localparam int REM  = WIDTH - LO;
    localparam bit LAST = (s == STAGES - 1);
    localparam int SQW  = LAST ? WIDTH + 1 : LO + SW;

    logic [REM-1:0]   a_i, b_i;
    logic             c_i;
    logic [TAG_W-1:0] t_i, tag_q;
    logic [NG-1:0]    gp, gg, co;
    logic [NG:0]      cg;
    logic [SW-1:0]    sl;
    logic [SQW-1:0]   sum_n, sum_q;
    logic             gpp, gacc;

    // Stage inputs: the port for stage 0, the previous stage's registers otherwise.
    if (s == 0) begin : g_src
      assign a_i = in_a;
      assign b_i = b_x;
      assign c_i = c0;
      assign t_i = in_tag;
    end else begin : g_src
      assign a_i = stg[s-1].g_hold.a_q;
      assign b_i = stg[s-1].g_hold.b_q;
      assign c_i = stg[s-1].g_hold.c_q;
      assign t_i = stg[s-1].tag_q;
    end

    for (genvar k = 0; k < NG; k++) begin : grp
      cla_group #(.GROUP_W(GROUP_W)) u_grp (
        .a    (a_i[k*GROUP_W +: GROUP_W]),
        .b    (b_i[k*GROUP_W +: GROUP_W]),
        .cin  (cg[k]),
        .s    (sl[k*GROUP_W +: GROUP_W]),
        .p    (gp[k]),
        .g    (gg[k]),
        .cout (co[k])
      );
    end

    // Second lookahead level: carry into every group from group P/G.
    always_comb begin
      cg    = '0;
      gpp   = 1'b1;
      gacc  = 1'b0;
      cg[0] = c_i;
      for (int k = 1; k <= NG; k++) begin
        gpp  = 1'b1;
        gacc = 1'b0;
        for (int j = k - 1; j >= 0; j--) begin
          gacc = gacc | (gpp & gg[j]);
          gpp  = gpp & gp[j];
        end
        cg[k] = gacc | (gpp & c_i);
      end
    end

    // A group's own carry-out must agree with the lookahead carry above it.
    always @(negedge clk) begin
      if (rst_n) assert (co == cg[NG:1]);
    end

    // Partial sum grows by one slice per stage; the last stage adds the
    // sign-extension bit a'[W-1] ^ b'[W-1] ^ C[W].
    if (LAST && s == 0) begin : g_sum
      assign sum_n = {a_i[REM-1] ^ b_i[REM-1] ^ cg[NG], sl};
    end else if (LAST) begin : g_sum
      assign sum_n = {a_i[REM-1] ^ b_i[REM-1] ^ cg[NG], sl, stg[s-1].sum_q};
    end else if (s == 0) begin : g_sum
      assign sum_n = sl;
    end else begin : g_sum
      assign sum_n = {sl, stg[s-1].sum_q};
    end

    // Non-final stages also carry the unconsumed operand bits and the carry.
    if (!LAST) begin : g_hold
      logic [REM-SW-1:0] a_q, b_q;
      logic              c_q;

      // Operand/carry hand-off to the next slice.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
        end else if (en) begin
          a_q <= a_i[REM-1:SW];
          b_q <= b_i[REM-1:SW];
          c_q <= cg[NG];
        end
      end
    end

    // Partial sum and tag register for this stage.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        tag_q <= '0;
      end else if (en) begin
        sum_q <= sum_n;
        tag_q <= t_i;
      end
    end
  end

  assign out_sum = stg[STAGES-1].sum_q;
  assign out_tag = stg[STAGES-1].tag_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed corner cases, streaming, backpressure,
// mid-flight reset and a randomized sweep over three configurations, all
// checked against a signed-arithmetic reference model.
module tb_cla_pipe_addsub;
  import cla_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic [31:0] a_w = '0, b_w = '0;
  op_e         op_r = OP_ADD;
  logic        cin_r = 1'b0;
  logic [3:0]  tag_r = '0;
  logic        or0 = 1'b1, or1 = 1'b1, or2 = 1'b1;
  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [16:0] s0;
  logic [8:0]  s1;
  logic [32:0] s2;
  logic [3:0]  t0, t1, t2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [32:0] sum;
    logic [3:0]  tag;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(16), .GROUP_W(4), .STAGES(2), .TAG_W(4)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_ready(ir0),
    .in_a(a_w[15:0]), .in_b(b_w[15:0]), .in_op(op_r), .in_cin(cin_r), .in_tag(tag_r),
    .out_valid(ov0), .out_ready(or0), .out_sum(s0), .out_tag(t0));

  cla_pipe_addsub #(.WIDTH(8), .GROUP_W(2), .STAGES(1), .TAG_W(4)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_ready(ir1),
    .in_a(a_w[7:0]), .in_b(b_w[7:0]), .in_op(op_r), .in_cin(cin_r), .in_tag(tag_r),
    .out_valid(ov1), .out_ready(or1), .out_sum(s1), .out_tag(t1));

  cla_pipe_addsub #(.WIDTH(32), .GROUP_W(4), .STAGES(4), .TAG_W(4)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(vld), .in_ready(ir2),
    .in_a(a_w), .in_b(b_w), .in_op(op_r), .in_cin(cin_r), .in_tag(tag_r),
    .out_valid(ov2), .out_ready(or2), .out_sum(s2), .out_tag(t2));

  // Reference: interpret the low w bits as two's complement.
  function automatic longint sx(input logic [31:0] a, input int w);
    logic [63:0] v;
    v = {32'd0, a} & ((64'd1 << w) - 64'd1);
    if (v[w-1]) v = v - (64'd1 << w);
    return longint'(v);
  endfunction

  // Reference: sext(A) +/- sext(B) +/- cin, kept to w+1 bits.
  function automatic logic [32:0] ref_sum(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic op, input logic cin);
    longint sa, sb, r;
    logic [63:0] u;
    sa = sx(a, w);
    sb = sx(b, w);
    if (op) r = sa - sb - longint'(cin);
    else    r = sa + sb + longint'(cin);
    u = r;
    u = u & ((64'd1 << (w + 1)) - 64'd1);
    return u[32:0];
  endfunction

  task automatic randomize_beat(input logic [3:0] tag);
    a_w   = $urandom;
    b_w   = $urandom;
    op_r  = op_e'($urandom_range(0, 1));
    cin_r = 1'($urandom_range(0, 1));
    tag_r = tag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld   = 1'b0;
    #2;
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", ov0); end
    total++; if (s0 !== 17'h0) begin bad++; $display("FAIL rst_out_sum: got %h want 0", s0); end
    total++; if (t0 !== 4'h0) begin bad++; $display("FAIL rst_out_tag: got %h want 0", t0); end
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", ir0); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL post_rst_valid: got %b want 0", ov0); end
    total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", ir0); end
  endtask

  task automatic test_directed();
    logic [15:0] ta [5] = '{16'h7FFF, 16'h8000, 16'h0000, 16'h8000, 16'hFFFF};
    logic [15:0] tb [5] = '{16'h0001, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000};
    logic        top [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        tc  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  tt  [5] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd8};
    logic [16:0] te  [5] = '{17'h08000, 17'h10000, 17'h1FFFF, 17'h10000, 17'h00000};
    or0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vld = 1'b1; a_w = {16'd0, ta[i]}; b_w = {16'd0, tb[i]};
      op_r = op_e'(top[i]); cin_r = tc[i]; tag_r = tt[i];
      @(posedge clk);
      #1 vld = 1'b0;
      @(negedge clk);
      total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL dir%0d_early_valid: got %b want 0", i, ov0); end
      @(negedge clk);
      total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL dir%0d_valid: got %b want 1", i, ov0); end
      total++; if (s0 !== te[i]) begin bad++; $display("FAIL dir%0d_sum: got %h want %h", i, s0, te[i]); end
      total++; if (t0 !== tt[i]) begin bad++; $display("FAIL dir%0d_tag: got %h want %h", i, t0, tt[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0, got = 0, first = -1, last = -1;
    exp_t e;
    or0 = 1'b1;
    q0.delete();
    @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (sent < 8) begin vld = 1'b1; randomize_beat(4'(sent)); end
      else vld = 1'b0;
      @(negedge clk);
      if (ov0) begin
        total++;
        if (q0.size() == 0) begin bad++; $display("FAIL b2b_spurious: got tag %h want none", t0); end
        else begin
          e = q0.pop_front();
          if (s0 !== e.sum[16:0] || t0 !== e.tag) begin
            bad++; $display("FAIL b2b_result: got %h/%h want %h/%h", s0, t0, e.sum[16:0], e.tag);
          end
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (vld) begin
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL b2b_in_ready: got %b want 1", ir0); end
        if (ir0) begin
          e.sum = ref_sum(16, a_w, b_w, op_r == OP_SUB, cin_r);
          e.tag = tag_r;
          q0.push_back(e);
          sent++;
        end
      end
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
    total++; if (got !== 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", got); end
    total++; if (last - first !== 7) begin bad++; $display("FAIL b2b_span: got %0d want 7", last - first); end
    total++; if (q0.size() !== 0) begin bad++; $display("FAIL b2b_left: got %0d want 0", q0.size()); end
  endtask

  task automatic test_backpressure();
    int   idx = 0, cur = -1, got = 0, stalls = 0;
    logic stall;
    exp_t e;
    q0.delete();
    for (int cyc = 0; cyc < 30; cyc++) begin
      or0 = !(cyc >= 3 && cyc < 8);
      if (idx < 6) begin
        if (idx != cur) begin randomize_beat(4'(idx)); cur = idx; end
        vld = 1'b1;
      end else vld = 1'b0;
      @(negedge clk);
      stall = ov0 && !or0;
      if (stall) begin
        stalls++;
        total++; if (ir0 !== 1'b0) begin bad++; $display("FAIL bp_in_ready_stall: got %b want 0", ir0); end
        total++;
        if (q0.size() == 0) begin bad++; $display("FAIL bp_stall_empty: got tag %h want none", t0); end
        else if (s0 !== q0[0].sum[16:0] || t0 !== q0[0].tag) begin
          bad++; $display("FAIL bp_hold: got %h/%h want %h/%h", s0, t0, q0[0].sum[16:0], q0[0].tag);
        end
      end else begin
        total++; if (ir0 !== 1'b1) begin bad++; $display("FAIL bp_in_ready: got %b want 1", ir0); end
      end
      if (ov0 && or0) begin
        total++;
        if (q0.size() == 0) begin bad++; $display("FAIL bp_spurious: got tag %h want none", t0); end
        else begin
          e = q0.pop_front();
          if (s0 !== e.sum[16:0] || t0 !== e.tag) begin
            bad++; $display("FAIL bp_result: got %h/%h want %h/%h", s0, t0, e.sum[16:0], e.tag);
          end
        end
        got++;
      end
      if (vld && ir0) begin
        e.sum = ref_sum(16, a_w, b_w, op_r == OP_SUB, cin_r);
        e.tag = tag_r;
        q0.push_back(e);
        idx++;
      end
      @(posedge clk);
      #1;
    end
    vld = 1'b0;
    or0 = 1'b1;
    total++; if (stalls !== 5) begin bad++; $display("FAIL bp_stall_cycles: got %0d want 5", stalls); end
    total++; if (got !== 6) begin bad++; $display("FAIL bp_count: got %0d want 6", got); end
    total++; if (q0.size() !== 0) begin bad++; $display("FAIL bp_left: got %0d want 0", q0.size()); end
  endtask

  task automatic test_reset_midflight();
    or0 = 1'b1;
    @(posedge clk);
    #1 vld = 1'b1; a_w = 32'd5; b_w = 32'd6; op_r = OP_ADD; cin_r = 1'b0; tag_r = 4'd9;
    @(posedge clk);
    #1 a_w = 32'd7; tag_r = 4'd10;
    @(posedge clk);
    #1 vld = 1'b0; rst_n = 1'b0;
    #1;
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL mrst_valid: got %b want 0", ov0); end
    total++; if (s0 !== 17'h0) begin bad++; $display("FAIL mrst_sum: got %h want 0", s0); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL mrst_stale%0d: got %b want 0", i, ov0); end
    end
    @(posedge clk);
    #1 vld = 1'b1; a_w = 32'd1; b_w = 32'd1; op_r = OP_ADD; cin_r = 1'b0; tag_r = 4'd4;
    @(posedge clk);
    #1 vld = 1'b0;
    @(negedge clk);
    total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL mrst_early: got %b want 0", ov0); end
    @(negedge clk);
    total++; if (ov0 !== 1'b1) begin bad++; $display("FAIL mrst_fresh_valid: got %b want 1", ov0); end
    total++; if (s0 !== 17'h00002) begin bad++; $display("FAIL mrst_fresh_sum: got %h want 00002", s0); end
    total++; if (t0 !== 4'd4) begin bad++; $display("FAIL mrst_fresh_tag: got %h want 4", t0); end
  endtask

  task automatic test_random_sweep();
    exp_t e;
    int   pops = 0;
    vld = 1'b0; or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    q0.delete(); q1.delete(); q2.delete();
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc < 400) begin
        vld = ($urandom_range(0, 3) != 0);
        randomize_beat(4'($urandom_range(0, 15)));
        or0 = ($urandom_range(0, 3) != 0);
        or1 = ($urandom_range(0, 3) != 0);
        or2 = ($urandom_range(0, 3) != 0);
      end else begin
        vld = 1'b0; or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
      end
      @(negedge clk);
      if (ov0 && or0) begin
        total++; pops++;
        if (q0.size() == 0) begin bad++; $display("FAIL rnd_w16_spurious: got tag %h want none", t0); end
        else begin
          e = q0.pop_front();
          if (s0 !== e.sum[16:0] || t0 !== e.tag) begin
            bad++; $display("FAIL rnd_w16: got %h/%h want %h/%h", s0, t0, e.sum[16:0], e.tag);
          end
        end
      end
      if (ov1 && or1) begin
        total++; pops++;
        if (q1.size() == 0) begin bad++; $display("FAIL rnd_w8_spurious: got tag %h want none", t1); end
        else begin
          e = q1.pop_front();
          if (s1 !== e.sum[8:0] || t1 !== e.tag) begin
            bad++; $display("FAIL rnd_w8: got %h/%h want %h/%h", s1, t1, e.sum[8:0], e.tag);
          end
        end
      end
      if (ov2 && or2) begin
        total++; pops++;
        if (q2.size() == 0) begin bad++; $display("FAIL rnd_w32_spurious: got tag %h want none", t2); end
        else begin
          e = q2.pop_front();
          if (s2 !== e.sum || t2 !== e.tag) begin
            bad++; $display("FAIL rnd_w32: got %h/%h want %h/%h", s2, t2, e.sum, e.tag);
          end
        end
      end
      e.tag = tag_r;
      if (vld && ir0) begin e.sum = ref_sum(16, a_w, b_w, op_r == OP_SUB, cin_r); q0.push_back(e); end
      if (vld && ir1) begin e.sum = ref_sum(8, a_w, b_w, op_r == OP_SUB, cin_r);  q1.push_back(e); end
      if (vld && ir2) begin e.sum = ref_sum(32, a_w, b_w, op_r == OP_SUB, cin_r); q2.push_back(e); end
      @(posedge clk);
      #1;
    end
    total++; if (pops < 300) begin bad++; $display("FAIL rnd_activity: got %0d want >=300", pops); end
    total++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      bad++; $display("FAIL rnd_left: got %0d/%0d/%0d want 0/0/0", q0.size(), q1.size(), q2.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
